// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator:
//   - default timing constants (800x600 @ 50 MHz pixel clock)
//   - test-pattern mode enumeration
//   - 8-entry colour-bar table and a lookup helper
// Counters and the x/y outputs are CNT_W bits wide.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int CNT_W = 12;

  // Default timing, in pixel-clock cycles (horizontal) and lines (vertical).
  localparam int DEF_H_SYNC   = 120;
  localparam int DEF_H_BP     = 64;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 56;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 23;
  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 37;
  localparam int DEF_HS_POL   = 0;
  localparam int DEF_VS_POL   = 0;
  localparam int DEF_COLOR_W  = 4;
  localparam int DEF_GRID     = 32;

  typedef enum logic [1:0] {
    PASS  = 2'd0,  // external pixel data
    SOLID = 2'd1,  // full white
    BARS  = 2'd2,  // eight vertical colour bars
    GRID  = 2'd3   // white grid lines on black
  } mode_t;

  // Bar colours as {r,g,b} on/off flags; entry i lives at bits [3*i +: 3].
  // Order from the left edge: white, yellow, cyan, green, magenta, red,
  // blue, black.
  localparam logic [23:0] BAR_TABLE = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return BAR_TABLE[3*idx +: 3];
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundles the pixel-source and display-side signals of vga_timing_gen.
//   master : the timing generator (drives req/x/y, syncs, de, colour)
//   slave  : the pixel source / display sink (drives mode and pix_*)
// Parameter COLOR_W: bits per colour channel.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int COLOR_W = 4
);
  import vga_pkg::*;

  logic [1:0]         mode;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic               req;
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               frame_start;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;

  modport master (
    input  mode, pix_r, pix_g, pix_b,
    output req, x, y, frame_start, hsync, vsync, de, vga_r, vga_g, vga_b
  );

  modport slave (
    output mode, pix_r, pix_g, pix_b,
    input  req, x, y, frame_start, hsync, vsync, de, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/vga_tpg.sv
// -----------------------------------------------------------------------------
// vga_tpg
// Test-pattern generator, only built when VGA_TPG_EN is defined.
// Latches the pattern mode at the first cycle of each frame and keeps bar /
// grid position counters that are updated on the same edge as the x/y
// registers of the timing generator, so every output here lines up with
// stage 1 (req, x, y). Positions come from wrap-around counters; no divide
// or modulo hardware is used.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   mode                requested pattern (latched on frame0)
//   frame0              stage-0 flag: h_cnt = 0 and v_cnt = 0
//   act0                stage-0 flag: counters inside the active window
//   line0               stage-0 flag: first active pixel of an active line
//   vfirst0             stage-0 flag: v_cnt is the first active line
//   pix_r/g/b           external pixel data (stage-1 aligned)
//   pat_r/g/b           selected pattern colour (stage-1 aligned)
// -----------------------------------------------------------------------------
`ifdef VGA_TPG_EN
module vga_tpg
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int GRID_PX  = DEF_GRID
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               frame0,
  input  logic               act0,
  input  logic               line0,
  input  logic               vfirst0,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic [COLOR_W-1:0] pat_r,
  output logic [COLOR_W-1:0] pat_g,
  output logic [COLOR_W-1:0] pat_b
);

  // Bars 0..6 are exactly BAR_W wide; bar 7 takes whatever is left.
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  mode_t            mode_reg;
  logic [CNT_W-1:0] bar_px_reg;
  logic [2:0]       bar_idx_reg;
  logic [CNT_W-1:0] gx_reg;
  logic [CNT_W-1:0] gy_reg;
  logic [2:0]       rgb;
  logic             grid_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg    <= PASS;
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
      gx_reg      <= '0;
      gy_reg      <= '0;
    end else begin
      if (frame0) begin
        mode_reg <= mode_t'(mode);
      end
      if (line0) begin
        // Start of an active line: x restarts, y steps by one line.
        bar_px_reg  <= '0;
        bar_idx_reg <= '0;
        gx_reg      <= '0;
        if (vfirst0) begin
          gy_reg <= '0;
        end else if (gy_reg == CNT_W'(GRID_PX - 1)) begin
          gy_reg <= '0;
        end else begin
          gy_reg <= gy_reg + 1'b1;
        end
      end else if (act0) begin
        if (gx_reg == CNT_W'(GRID_PX - 1)) begin
          gx_reg <= '0;
        end else begin
          gx_reg <= gx_reg + 1'b1;
        end
        // Once on the last bar, stop counting so it absorbs the remainder.
        if (bar_idx_reg != 3'd7) begin
          if (bar_px_reg == CNT_W'(BAR_W - 1)) begin
            bar_px_reg  <= '0;
            bar_idx_reg <= bar_idx_reg + 3'd1;
          end else begin
            bar_px_reg <= bar_px_reg + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rgb     = bar_rgb(bar_idx_reg);
    grid_on = (gx_reg == '0) || (gy_reg == '0);
    pat_r   = pix_r;
    pat_g   = pix_g;
    pat_b   = pix_b;
    case (mode_reg)
      SOLID: begin
        pat_r = '1;
        pat_g = '1;
        pat_b = '1;
      end
      BARS: begin
        pat_r = {COLOR_W{rgb[2]}};
        pat_g = {COLOR_W{rgb[1]}};
        pat_b = {COLOR_W{rgb[0]}};
      end
      GRID: begin
        pat_r = {COLOR_W{grid_on}};
        pat_g = {COLOR_W{grid_on}};
        pat_b = {COLOR_W{grid_on}};
      end
      default: ;
    endcase
  end

endmodule
`endif

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA timing generator with optional test-pattern generator.
// Optional feature macro: VGA_TPG_EN (builds vga_tpg and honours mode;
// otherwise mode is ignored and the output is the registered pix_* data).
//
// Pipeline:
//   stage 0  h_cnt / v_cnt counters (sync, back porch, active, front porch)
//   stage 1  req, x, y, and internal sync / frame flags
//   stage 2  hsync, vsync, de, frame_start, vga_* -- all mutually aligned
// pix_* is captured on the cycle req is high, so the external source may
// decode x and y combinationally.
//
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   mode                pattern select (latched at frame start)
//   pix_r/g/b           external pixel data
//   req, x, y           external pixel request and active coordinate
//   frame_start         one-cycle pulse at stage 2 of h_cnt = 0, v_cnt = 0
//   hsync, vsync, de    display timing
//   vga_r/g/b           pixel colour, zero outside de
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int HS_POL   = DEF_HS_POL,
  parameter int VS_POL   = DEF_VS_POL,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int GRID     = DEF_GRID
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
  output logic               req,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int H_END   = H_START + H_ACTIVE;
  localparam int V_START = V_SYNC + V_BP;
  localparam int V_END   = V_START + V_ACTIVE;

  localparam logic HS_ON   = (HS_POL != 0);
  localparam logic HS_IDLE = !HS_ON;
  localparam logic VS_ON   = (VS_POL != 0);
  localparam logic VS_IDLE = !VS_ON;

  // Stage 0: counters.
  logic [CNT_W-1:0] h_cnt_reg, h_cnt_next;
  logic [CNT_W-1:0] v_cnt_reg, v_cnt_next;
  logic             h_act0, v_act0, act0, frame0;

  // Stage 1.
  logic             req_reg;
  logic [CNT_W-1:0] x_reg, y_reg;
  logic             hs1_reg, vs1_reg, fs1_reg;

  // Stage 2.
  logic               de_reg, hsync_reg, vsync_reg, frame_start_reg;
  logic [COLOR_W-1:0] vga_r_reg, vga_g_reg, vga_b_reg;

  // Colour source feeding stage 2 (stage-1 aligned).
  logic [COLOR_W-1:0] col_r, col_g, col_b;

  always_comb begin
    h_cnt_next = h_cnt_reg + 1'b1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == CNT_W'(H_TOTAL - 1)) begin
      h_cnt_next = '0;
      if (v_cnt_reg == CNT_W'(V_TOTAL - 1)) begin
        v_cnt_next = '0;
      end else begin
        v_cnt_next = v_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  always_comb begin
    h_act0 = (h_cnt_reg >= CNT_W'(H_START)) && (h_cnt_reg < CNT_W'(H_END));
    v_act0 = (v_cnt_reg >= CNT_W'(V_START)) && (v_cnt_reg < CNT_W'(V_END));
    act0   = h_act0 && v_act0;
    frame0 = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_reg <= 1'b0;
      x_reg   <= '0;
      y_reg   <= '0;
      hs1_reg <= HS_IDLE;
      vs1_reg <= VS_IDLE;
      fs1_reg <= 1'b0;
    end else begin
      req_reg <= act0;
      x_reg   <= act0 ? (h_cnt_reg - CNT_W'(H_START)) : '0;
      y_reg   <= act0 ? (v_cnt_reg - CNT_W'(V_START)) : '0;
      hs1_reg <= (h_cnt_reg < CNT_W'(H_SYNC)) ? HS_ON : HS_IDLE;
      // v_cnt only moves when h_cnt wraps, so vsync edges fall on h_cnt = 0.
      vs1_reg <= (v_cnt_reg < CNT_W'(V_SYNC)) ? VS_ON : VS_IDLE;
      fs1_reg <= frame0;
    end
  end

`ifdef VGA_TPG_EN
  logic line0, vfirst0;

  always_comb begin
    line0   = (h_cnt_reg == CNT_W'(H_START)) && v_act0;
    vfirst0 = (v_cnt_reg == CNT_W'(V_START));
  end

  vga_tpg #(
    .H_ACTIVE (H_ACTIVE),
    .COLOR_W  (COLOR_W),
    .GRID_PX  (GRID)
  ) u_tpg (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .frame0  (frame0),
    .act0    (act0),
    .line0   (line0),
    .vfirst0 (vfirst0),
    .pix_r   (pix_r),
    .pix_g   (pix_g),
    .pix_b   (pix_b),
    .pat_r   (col_r),
    .pat_g   (col_g),
    .pat_b   (col_b)
  );
`else
  // Pattern generator not built: mode has no effect.
  logic unused_mode;
  assign unused_mode = ^mode;

  always_comb begin
    col_r = pix_r;
    col_g = pix_g;
    col_b = pix_b;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      de_reg          <= 1'b0;
      hsync_reg       <= HS_IDLE;
      vsync_reg       <= VS_IDLE;
      frame_start_reg <= 1'b0;
      vga_r_reg       <= '0;
      vga_g_reg       <= '0;
      vga_b_reg       <= '0;
    end else begin
      de_reg          <= req_reg;
      hsync_reg       <= hs1_reg;
      vsync_reg       <= vs1_reg;
      frame_start_reg <= fs1_reg;
      // Blank the colour outside the active window.
      vga_r_reg       <= req_reg ? col_r : '0;
      vga_g_reg       <= req_reg ? col_g : '0;
      vga_b_reg       <= req_reg ? col_b : '0;
    end
  end

  assign req         = req_reg;
  assign x           = x_reg;
  assign y           = y_reg;
  assign de          = de_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign frame_start = frame_start_reg;
  assign vga_r       = vga_r_reg;
  assign vga_g       = vga_g_reg;
  assign vga_b       = vga_b_reg;

endmodule
